// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters.
// Each requester has a valid/ready request channel and a valid/ready response
// channel. Only one operation is in flight at a time. The FSM walks through
// IDLE (arbitrate and capture), EXEC (ALU evaluates the registered operands)
// and RESP (hold the result until the owner takes it).
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_result,
  output logic                     rsp0_err,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_result,
  output logic                     rsp1_err,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     owner;
  logic                     last_grant;
  logic [DATA_WIDTH-1:0]    a_reg;
  logic [DATA_WIDTH-1:0]    b_reg;
  logic [OPCODE_LENGTH-1:0] op_reg;
  logic [DATA_WIDTH-1:0]    result_reg;
  logic                     err_reg;
  logic                     grant0;
  logic                     grant1;
  logic                     accept;

  // The ALU implements AND (0000), ADD (0010), Equal (1000), NotEqual (1001).
  function automatic logic op_unsupported(input logic [OPCODE_LENGTH-1:0] op);
    return !((op == OPCODE_LENGTH'(0)) || (op == OPCODE_LENGTH'(2)) ||
             (op == OPCODE_LENGTH'(8)) || (op == OPCODE_LENGTH'(9)));
  endfunction

  // Round-robin grant; ready is also masked by reset so all outputs read 0 while it is held.
  always_comb begin
    grant0     = req0_valid & (!req1_valid | last_grant);
    grant1     = req1_valid & !grant0;
    req0_ready = (state == IDLE) & grant0 & !reset;
    req1_ready = (state == IDLE) & grant1 & !reset;
    accept     = req0_ready | req1_ready;
  end

  // Next-state logic; a new grant only happens from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (owner ? rsp1_ready : rsp0_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture at the request handshake, result/err capture in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        a_reg      <= grant1 ? req1_a  : req0_a;
        b_reg      <= grant1 ? req1_b  : req0_b;
        op_reg     <= grant1 ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        result_reg <= alu_result;
        err_reg    <= op_unsupported(op_reg);
      end
    end
  end

  // ALU ports come only from the operand registers; responses read 0 unless valid.
  always_comb begin
    alu_srca    = a_reg;
    alu_srcb    = b_reg;
    alu_op      = op_reg;
    rsp0_valid  = (state == RESP) & !owner;
    rsp1_valid  = (state == RESP) & owner;
    rsp0_result = rsp0_valid ? result_reg : '0;
    rsp1_result = rsp1_valid ? result_reg : '0;
    rsp0_err    = rsp0_valid & err_reg;
    rsp1_err    = rsp1_valid & err_reg;
  end

endmodule
